// File: rtl/fifo_level.sv
// Single-clock circular-buffer FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow errors and a choice of fall-through or registered read port.
module fifo_level #(
  parameter int DATA_BITS   = 10,
  parameter int FIFO_LENGTH = 16,
  parameter int ADDR_BIT    = $clog2(FIFO_LENGTH),
  parameter int AF_LEVEL    = 12,
  parameter int AE_LEVEL    = 4,
  parameter int OUT_REG     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] input_data,
  input  logic                 write,
  input  logic                 read,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] output_data,
  output logic                 output_valid,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [ADDR_BIT:0]    count,
  output logic                 overflow,
  output logic                 underflow
);

  // Handshake: a write is taken when write=1 and there is room (or a read frees a slot in
  // the same cycle); a read is taken when read=1 and the FIFO is non-empty. Both are judged
  // on the state before the clock edge; rejected requests raise the sticky error flags.

  localparam int CW = ADDR_BIT + 1;
  localparam logic [ADDR_BIT-1:0] LAST_PTR = ADDR_BIT'(FIFO_LENGTH - 1);
  localparam logic [CW-1:0]       DEPTH    = CW'(FIFO_LENGTH);
  localparam logic [CW-1:0]       AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0]       AE_CNT   = CW'(AE_LEVEL);

  logic [DATA_BITS-1:0] mem_q [FIFO_LENGTH];
  logic [ADDR_BIT-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_BIT-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 wr_ok, rd_ok;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH);
  assign almost_empty = (count_q <= AE_CNT);
  assign almost_full  = (count_q >= AF_CNT);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    rd_ok    = read & ~empty;
    wr_ok    = write & (~full | rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Explicit wrap so depths that are not a power of two work.
    if (wr_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    overflow_d  = (write & ~wr_ok) | (overflow_q & ~clr_err);
    underflow_d = (read & ~rd_ok) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem_q[wr_ptr_q] <= input_data;
  end

  if (OUT_REG != 0) begin : g_reg
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;

    always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = rd_ok;
      if (rd_ok) out_data_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_data_q  <= out_data_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign output_data  = out_data_q;
    assign output_valid = out_valid_q;
  end else begin : g_fwft
    assign output_data  = mem_q[rd_ptr_q];
    assign output_valid = ~empty;
  end

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: a 16-deep fall-through instance and a 5-deep registered-read
// instance, both compared every cycle against queue-based reference models.
module tb_fifo_level;

  localparam int DW = 10;
  localparam int N0 = 16;
  localparam int N1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          clr;
  logic [DW-1:0] in0, out0, in1, out1;
  logic          wr0, rd0, val0, emp0, ful0, ae0, af0, ovf0, udf0;
  logic          wr1, rd1, val1, emp1, ful1, ae1, af1, ovf1, udf1;
  logic [4:0]    cnt0;
  logic [3:0]    cnt1;

  fifo_level #(.DATA_BITS(DW), .FIFO_LENGTH(N0), .AF_LEVEL(12), .AE_LEVEL(4), .OUT_REG(0)) dut0 (
    .clk(clk), .reset(reset), .input_data(in0), .write(wr0), .read(rd0), .clr_err(clr),
    .output_data(out0), .output_valid(val0), .empty(emp0), .full(ful0),
    .almost_empty(ae0), .almost_full(af0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

  fifo_level #(.DATA_BITS(DW), .FIFO_LENGTH(N1), .AF_LEVEL(4), .AE_LEVEL(1), .OUT_REG(1)) dut1 (
    .clk(clk), .reset(reset), .input_data(in1), .write(wr1), .read(rd1), .clr_err(clr),
    .output_data(out1), .output_valid(val1), .empty(emp1), .full(ful1),
    .almost_empty(ae1), .almost_full(af1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

  // Reference models: plain queues plus sticky flags and the registered read word.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit            ov0_m, uf0_m, ov1_m, uf1_m, v1_m;
  logic [DW-1:0] od1_m;
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic logic [11:0] exp_stat0();
    int n = q0.size();
    return {5'(n), n == 0, n == N0, n <= 4, n >= 12, ov0_m, uf0_m, n != 0};
  endfunction

  function automatic logic [11:0] act_stat0();
    return {cnt0, emp0, ful0, ae0, af0, ovf0, udf0, val0};
  endfunction

  function automatic logic [20:0] exp_stat1();
    int n = q1.size();
    return {4'(n), n == 0, n == N1, n <= 1, n >= 4, ov1_m, uf1_m, v1_m, od1_m};
  endfunction

  function automatic logic [20:0] act_stat1();
    return {cnt1, emp1, ful1, ae1, af1, ovf1, udf1, val1, out1};
  endfunction

  // Drive one cycle on both instances, advance the models at the edge, settle 1ns after.
  task automatic step(input bit w0, input bit r0, input logic [DW-1:0] d0,
                      input bit w1, input bit r1, input logic [DW-1:0] d1, input bit c);
    bit rok, wok;
    logic [DW-1:0] popped;
    wr0 = w0; rd0 = r0; in0 = d0; wr1 = w1; rd1 = r1; in1 = d1; clr = c;
    @(posedge clk);
    if (!reset) begin
      q0.delete(); q1.delete();
      ov0_m = 0; uf0_m = 0; ov1_m = 0; uf1_m = 0; v1_m = 0; od1_m = '0;
    end else begin
      rok = r0 && q0.size() > 0;
      wok = w0 && (q0.size() < N0 || rok);
      if (rok) popped = q0.pop_front();
      if (wok) q0.push_back(d0);
      ov0_m = (w0 && !wok) || (ov0_m && !c);
      uf0_m = (r0 && !rok) || (uf0_m && !c);
      rok = r1 && q1.size() > 0;
      wok = w1 && (q1.size() < N1 || rok);
      if (rok) begin
        popped = q1.pop_front();
        od1_m  = popped;
      end
      v1_m = rok;
      if (wok) q1.push_back(d1);
      ov1_m = (w1 && !wok) || (ov1_m && !c);
      uf1_m = (r1 && !rok) || (uf1_m && !c);
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    reset = 1'b1;
    n_checks++;
    if (act_stat0() !== 12'b00000_1010_000) $display("FAIL reset_stat0 got=%h exp=%h", act_stat0(), 12'b00000_1010_000);
    else n_pass++;
    n_checks++;
    if (act_stat1() !== {4'd0, 7'b1010_000, 10'd0}) $display("FAIL reset_stat1 got=%h exp=%h", act_stat1(), {4'd0, 7'b1010_000, 10'd0});
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= N0 + 1; i++) begin
      step(1, 0, 10'(i), 0, 0, '0, 0);
      n_checks++;
      if (act_stat0() !== exp_stat0()) $display("FAIL fill_stat w=%0d got=%h exp=%h", i, act_stat0(), exp_stat0());
      else n_pass++;
    end
    n_checks++;
    if ({ovf0, cnt0} !== {1'b1, 5'd16}) $display("FAIL fill_overflow got=%b/%0d exp=1/16", ovf0, cnt0);
    else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < N0; i++) begin
      n_checks++;
      if (out0 !== 10'(i + 1)) $display("FAIL drain_data i=%0d got=%h exp=%h", i, out0, 10'(i + 1));
      else n_pass++;
      step(0, 1, '0, 0, 0, '0, 0);
      n_checks++;
      if (act_stat0() !== exp_stat0()) $display("FAIL drain_stat i=%0d got=%h exp=%h", i, act_stat0(), exp_stat0());
      else n_pass++;
    end
    step(0, 1, '0, 0, 0, '0, 0);
    n_checks++;
    if ({udf0, ovf0, emp0} !== 3'b111) $display("FAIL drain_underflow got=%b exp=111", {udf0, ovf0, emp0});
    else n_pass++;
    step(0, 0, '0, 0, 0, '0, 1);
    n_checks++;
    if ({udf0, ovf0} !== 2'b00) $display("FAIL clr_err got=%b exp=00", {udf0, ovf0});
    else n_pass++;
  endtask

  task automatic test_full_rw();
    logic [DW-1:0] e;
    for (int i = 1; i <= N0; i++) step(1, 0, 10'(i), 0, 0, '0, 0);
    step(1, 1, 10'h3FF, 0, 0, '0, 0);
    n_checks++;
    if ({cnt0, ful0, ovf0} !== {5'd16, 1'b1, 1'b0}) $display("FAIL full_rw got=%0d/%b/%b exp=16/1/0", cnt0, ful0, ovf0);
    else n_pass++;
    for (int i = 0; i < N0; i++) begin
      e = (i < N0 - 1) ? 10'(i + 2) : 10'h3FF;
      n_checks++;
      if (out0 !== e) $display("FAIL full_rw_drain i=%0d got=%h exp=%h", i, out0, e);
      else n_pass++;
      step(0, 1, '0, 0, 0, '0, 0);
    end
    n_checks++;
    if (act_stat0() !== exp_stat0()) $display("FAIL full_rw_end got=%h exp=%h", act_stat0(), exp_stat0());
    else n_pass++;
  endtask

  task automatic test_empty_rw();
    step(1, 1, 10'h055, 0, 0, '0, 0);
    n_checks++;
    if ({cnt0, udf0, ovf0} !== {5'd1, 1'b1, 1'b0}) $display("FAIL empty_rw got=%0d/%b/%b exp=1/1/0", cnt0, udf0, ovf0);
    else n_pass++;
    n_checks++;
    if (out0 !== 10'h055) $display("FAIL empty_rw_data got=%h exp=055", out0);
    else n_pass++;
    step(0, 1, '0, 0, 0, '0, 1);
    n_checks++;
    if (act_stat0() !== exp_stat0()) $display("FAIL empty_rw_read got=%h exp=%h", act_stat0(), exp_stat0());
    else n_pass++;
  endtask

  task automatic test_out_reg();
    logic [DW-1:0] exp_rd[7] = '{10'h00A, 10'h00B, 10'h00C, 10'h00D, 10'h00E, 10'h00F, 10'h010};
    int k = 0;
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 0, 10'(10 + i), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 0, 1, '0, 0);
      n_checks++;
      if ({val1, out1} !== {1'b1, exp_rd[k]}) $display("FAIL outreg_rd k=%0d got=%b/%h exp=1/%h", k, val1, out1, exp_rd[k]);
      else n_pass++;
      k++;
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, '0, 1, 0, 10'(15 + i), 0);
      n_checks++;
      if (act_stat1() !== exp_stat1()) $display("FAIL outreg_wr i=%0d got=%h exp=%h", i, act_stat1(), exp_stat1());
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0, 0, 1, '0, 0);
      n_checks++;
      if ({val1, out1} !== {1'b1, exp_rd[k]}) $display("FAIL outreg_rd k=%0d got=%b/%h exp=1/%h", k, val1, out1, exp_rd[k]);
      else n_pass++;
      k++;
    end
    idle();
    n_checks++;
    if ({val1, out1, emp1} !== {1'b0, 10'h010, 1'b1}) $display("FAIL outreg_hold got=%b/%h/%b exp=0/010/1", val1, out1, emp1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) step(1, 0, 10'($urandom_range(0, 1023)), 1, 0, 10'(i), 0);
    step(1, 1, '0, 0, 1, '0, 0);
    reset = 1'b0;
    step(1, 0, 10'h123, 1, 0, 10'h321, 0);
    reset = 1'b1;
    n_checks++;
    if (act_stat0() !== 12'b00000_1010_000) $display("FAIL reset_mid0 got=%h exp=%h", act_stat0(), 12'b00000_1010_000);
    else n_pass++;
    n_checks++;
    if (act_stat1() !== exp_stat1()) $display("FAIL reset_mid1 got=%h exp=%h", act_stat1(), exp_stat1());
    else n_pass++;
  endtask

  task automatic test_random();
    bit w0, r0, w1, r1, c;
    for (int i = 0; i < 600; i++) begin
      w0 = $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35);
      r0 = $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70);
      w1 = $urandom_range(0, 1) == 1;
      r1 = $urandom_range(0, 1) == 1;
      c  = $urandom_range(0, 15) == 0;
      step(w0, r0, 10'($urandom_range(0, 1023)), w1, r1, 10'($urandom_range(0, 1023)), c);
      n_checks++;
      if (act_stat0() !== exp_stat0()) $display("FAIL rand_stat0 i=%0d got=%h exp=%h", i, act_stat0(), exp_stat0());
      else n_pass++;
      if (q0.size() > 0) begin
        n_checks++;
        if (out0 !== q0[0]) $display("FAIL rand_data0 i=%0d got=%h exp=%h", i, out0, q0[0]);
        else n_pass++;
      end
      n_checks++;
      if (act_stat1() !== exp_stat1()) $display("FAIL rand_stat1 i=%0d got=%h exp=%h", i, act_stat1(), exp_stat1());
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0;
    wr0 = 1'b0; rd0 = 1'b0; in0 = '0;
    wr1 = 1'b0; rd1 = 1'b0; in1 = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_out_reg();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
